// File: rtl/capiano_key_pkg.sv
// capiano_key_pkg: shared constants, the event payload type and width helpers
// for the key event path.
// Optional build macro: KEY_EVT_TIMESTAMP_EN adds a 16-bit push-time stamp
// to each event.
package capiano_key_pkg;

    localparam int unsigned NUM_KEYS_DEFAULT   = 39;
    localparam int unsigned KEY_W_DEFAULT      = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;
    localparam int unsigned TIME_W             = 16;

    // Event payload at the default key width, as seen by the voice allocator.
    typedef struct packed {
        logic [KEY_W_DEFAULT-1:0] key;
        logic                     on;
`ifdef KEY_EVT_TIMESTAMP_EN
        logic [TIME_W-1:0]        stamp;
`endif
    } key_evt_t;

    // Ceiling log2, usable in constant expressions for port and pointer widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// key_evt_fifo: synchronous show-ahead FIFO with simultaneous push/pop.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   wr_en/wr_data push request and payload (caller guarantees space, or a
//                 same-cycle pop when full)
//   rd_en         pop request; ignored while empty
//   valid         head entry present
//   head          head entry payload (stable until popped)
//   count         current occupancy
module key_evt_fifo
    import capiano_key_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic                  valid,
    output logic [WIDTH-1:0]      head,
    output logic [clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = valid && rd_en;
    assign head   = mem[rd_ptr];

    // Storage, pointers (natural wrap) and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_encoder.sv
// key_event_encoder: turns per-key level changes into a queue of key-on/off
// events presented on a valid/ready interface. Transitions blocked by a full
// queue are deferred and re-evaluated, so a glitch that reverts before it is
// selected collapses to no event.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   key_down    per-key pressed level
//   evt_valid   head event present; evt_ready accepts it
//   evt_key     head event key index; evt_on 1 = key-on, 0 = key-off
//   fifo_count  queue occupancy
//   pending     some key differs from its last reported state (combinational)
//   evt_time    push-time tick of the head event (KEY_EVT_TIMESTAMP_EN only)
// Optional build macro: KEY_EVT_TIMESTAMP_EN.
module key_event_encoder
    import capiano_key_pkg::*;
#(
    parameter int unsigned NUM_KEYS   = NUM_KEYS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned KEY_W      = KEY_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_KEYS:0]          key_down,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [KEY_W-1:0]           evt_key,
    output logic                       evt_on,
    output logic [clog2(FIFO_DEPTH):0] fifo_count,
    output logic                       pending
`ifdef KEY_EVT_TIMESTAMP_EN
    ,
    output logic [TIME_W-1:0]          evt_time
`endif
);

    localparam int unsigned KW    = NUM_KEYS + 1;
    localparam int unsigned CNT_W = clog2(FIFO_DEPTH) + 1;

    // Queue entry at this instance's key width.
    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic              on;
`ifdef KEY_EVT_TIMESTAMP_EN
        logic [TIME_W-1:0] stamp;
`endif
    } entry_t;

    logic [KW-1:0]    reported;
    logic [KW-1:0]    diff;
    logic [KW-1:0]    sel_mask;
    logic [KEY_W-1:0] sel_key;
    logic             sel_on;
    logic             push;
    logic             pop;
    entry_t           wr_entry;
    entry_t           head;

    assign diff    = key_down ^ reported;
    assign pending = |diff;

    // Lowest set bit of diff: two's-complement isolation gives the winner mask.
    assign sel_mask = diff & (~diff + KW'(1));
    assign sel_on   = |(key_down & sel_mask);

    // One-hot to binary key index.
    always_comb begin
        sel_key = '0;
        for (int unsigned i = 0; i < KW; i++) begin
            if (sel_mask[i]) begin
                sel_key = sel_key | KEY_W'(i);
            end
        end
    end

    // A full queue still accepts when the head leaves on the same edge.
    assign pop  = evt_valid && evt_ready;
    assign push = pending && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop);

    // Last issued state per key; flips together with the enqueue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reported <= '0;
        end else if (push) begin
            reported <= reported ^ sel_mask;
        end
    end

`ifdef KEY_EVT_TIMESTAMP_EN
    logic [TIME_W-1:0] tick;

    // Free-running tick, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else begin
            tick <= tick + TIME_W'(1);
        end
    end
`endif

    always_comb begin
        wr_entry       = '0;
        wr_entry.key   = sel_key;
        wr_entry.on    = sel_on;
`ifdef KEY_EVT_TIMESTAMP_EN
        wr_entry.stamp = tick;
`endif
    end

    key_evt_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (evt_ready),
        .valid   (evt_valid),
        .head    (head),
        .count   (fifo_count)
    );

    assign evt_key  = head.key;
    assign evt_on   = head.on;
`ifdef KEY_EVT_TIMESTAMP_EN
    assign evt_time = head.stamp;
`endif

endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: directed and randomized stimulus against a queue-based
// reference model of the key event encoder.
module tb_key_event_encoder;

    localparam int unsigned NK    = 39;
    localparam int unsigned DEPTH = 8;

    typedef logic [NK:0] kvec_t;

    typedef struct {
        int key;
        int on;
        int stamp;
    } ev_t;

    logic       clk;
    logic       rst;
    kvec_t      key_down;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_key;
    logic       evt_on;
    logic [3:0] fifo_count;
    logic       pending;
`ifdef KEY_EVT_TIMESTAMP_EN
    logic [15:0] evt_time;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    key_event_encoder #(
        .NUM_KEYS   (NK),
        .FIFO_DEPTH (DEPTH),
        .KEY_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_down   (key_down),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_key    (evt_key),
        .evt_on     (evt_on),
        .fifo_count (fifo_count),
        .pending    (pending)
`ifdef KEY_EVT_TIMESTAMP_EN
        ,
        .evt_time   (evt_time)
`endif
    );

    ev_t   mq[$];
    ev_t   popped[$];
    kvec_t m_rep;
    int    m_tick;
    int    n_checks;
    int    n_errors;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic ev_t observed();
        ev_t e;
        e.key   = int'(evt_key);
        e.on    = int'(evt_on);
`ifdef KEY_EVT_TIMESTAMP_EN
        e.stamp = int'(evt_time);
`else
        e.stamp = 0;
`endif
        return e;
    endfunction

    task automatic check_outputs();
        check("evt_valid", 32'(evt_valid), 32'(mq.size() != 0));
        check("fifo_count", 32'(fifo_count), 32'(mq.size()));
        if (mq.size() != 0) begin
            check("evt_key", 32'(evt_key), 32'(mq[0].key));
            check("evt_on", 32'(evt_on), 32'(mq[0].on));
`ifdef KEY_EVT_TIMESTAMP_EN
            check("evt_time", 32'(evt_time), 32'(mq[0].stamp));
`endif
        end
    endtask

    // One clock: drive inputs, predict the edge, then compare after it.
    task automatic cycle(input kvec_t kd, input logic rdy);
        int    occ;
        int    sel;
        bit    do_pop;
        kvec_t d;
        key_down  = kd;
        evt_ready = rdy;
        #1;
        check("pending", 32'(pending), 32'(kd != m_rep));
        if (evt_valid && rdy) popped.push_back(observed());
        occ    = mq.size();
        do_pop = (occ != 0) && rdy;
        d      = kd ^ m_rep;
        sel    = -1;
        for (int i = 0; i <= int'(NK); i++) begin
            if (sel < 0 && d[i]) sel = i;
        end
        if (do_pop) void'(mq.pop_front());
        if (sel >= 0 && (occ < int'(DEPTH) || do_pop)) begin
            mq.push_back('{key: sel, on: int'(kd[sel]), stamp: m_tick});
            m_rep = m_rep ^ (kvec_t'(1) << sel);
        end
        m_tick = (m_tick + 1) % 65536;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic apply_reset(input kvec_t kd);
        key_down  = kd;
        evt_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_key", 32'(evt_key), 32'd0);
        check("rst_on", 32'(evt_on), 32'd0);
        #2;
        rst = 1'b0;
        mq.delete();
        m_rep  = '0;
        m_tick = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        kvec_t kd;
        int    n_on;
        int    n_k7;
        int    exp_keys[3];
        bit    rdy;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        key_down  = '0;
        evt_ready = 1'b0;
        m_rep     = '0;
        m_tick    = 0;
        #2;
        apply_reset('0);
        check("reset_pending", 32'(pending), 32'd0);

        // Single key press then release.
        cycle(kvec_t'(1) << 5, 1'b1);
        check("t1_on_key", 32'(evt_key), 32'd5);
        check("t1_on_on", 32'(evt_on), 32'd1);
        cycle('0, 1'b1);
        check("t1_off_key", 32'(evt_key), 32'd5);
        check("t1_off_on", 32'(evt_on), 32'd0);
        cycle('0, 1'b1);

        // Simultaneous presses drain lowest index first.
        popped.delete();
        kd = (kvec_t'(1) << 3) | kvec_t'(1) | (kvec_t'(1) << 39);
        repeat (4) cycle(kd, 1'b1);
        exp_keys = '{0, 3, 39};
        check("t2_count", 32'(popped.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < popped.size()) begin
                check("t2_key", 32'(popped[i].key), 32'(exp_keys[i]));
                check("t2_on", 32'(popped[i].on), 32'd1);
            end
        end
        kd = '0;
        repeat (5) cycle(kd, 1'b1);

        // Backpressure: ten presses, queue saturates at eight.
        kd = kvec_t'(10'h3FF) << 10;
        repeat (9) cycle(kd, 1'b0);
        check("t3_full", 32'(fifo_count), 32'd8);
        check("t3_pending", 32'(pending), 32'd1);

        // Key 7 glitches while the queue is full.
        cycle(kd | (kvec_t'(1) << 7), 1'b0);
        cycle(kd, 1'b0);
        popped.delete();
        repeat (16) cycle(kd, 1'b1);
        n_on = 0;
        n_k7 = 0;
        foreach (popped[i]) begin
            if (popped[i].key >= 10 && popped[i].key <= 19 && popped[i].on == 1) n_on++;
            if (popped[i].key == 7) n_k7++;
        end
        check("t3_all_on", 32'(n_on), 32'd10);
        check("t4_no_key7", 32'(n_k7), 32'd0);
        kd = '0;
        repeat (14) cycle(kd, 1'b1);

        // Reset with queued events while key 2 stays held.
        kd = (kvec_t'(1) << 2) | (kvec_t'(1) << 4) | (kvec_t'(1) << 6) | (kvec_t'(1) << 8);
        repeat (4) cycle(kd, 1'b0);
        check("t5_queued", 32'(fifo_count), 32'd4);
        apply_reset(kvec_t'(1) << 2);
        repeat (3) cycle(kvec_t'(1) << 2, 1'b0);
        check("t5_count", 32'(fifo_count), 32'd1);
        check("t5_key", 32'(evt_key), 32'd2);
        check("t5_on", 32'(evt_on), 32'd1);
        kd = '0;
        repeat (4) cycle(kd, 1'b1);

`ifdef KEY_EVT_TIMESTAMP_EN
        // Push-time stamps, then counter wrap.
        while (m_tick != 100) cycle(kd, 1'b1);
        popped.delete();
        kd = kvec_t'(1) << 1;
        repeat (3) cycle(kd, 1'b0);
        kd = kd | (kvec_t'(1) << 2);
        cycle(kd, 1'b0);
        repeat (3) cycle(kd, 1'b1);
        check("ts_n", 32'(popped.size()), 32'd2);
        if (popped.size() >= 2) begin
            check("ts_first", 32'(popped[0].stamp), 32'd100);
            check("ts_second", 32'(popped[1].stamp), 32'd103);
        end
        kd = '0;
        repeat (5) cycle(kd, 1'b1);
        repeat (65534 - m_tick) @(posedge clk);
        #1;
        m_tick = 65534;
        popped.delete();
        cycle(kvec_t'(1) << 3, 1'b0);
        cycle('0, 1'b0);
        cycle(kvec_t'(1) << 3, 1'b0);
        repeat (4) cycle(kvec_t'(1) << 3, 1'b1);
        check("wrap_n", 32'(popped.size()), 32'd3);
        if (popped.size() >= 3) begin
            check("wrap_a", 32'(popped[0].stamp), 32'd65534);
            check("wrap_b", 32'(popped[1].stamp), 32'd65535);
            check("wrap_c", 32'(popped[2].stamp), 32'd0);
        end
        kd = '0;
        repeat (4) cycle(kd, 1'b1);
`endif

        // Randomized traffic with alternating ready-heavy and stall-heavy phases.
        kd = '0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) kd = kd ^ (kvec_t'(1) << $urandom_range(0, NK));
            if ($urandom_range(0, 15) == 0) kd = kd ^ kvec_t'({$urandom, $urandom});
            if (((c / 50) % 2) == 1) rdy = ($urandom_range(0, 4) == 0);
            else rdy = ($urandom_range(0, 3) != 0);
            cycle(kd, rdy);
        end
        repeat (60) cycle(kd, 1'b1);
        check("final_pending", 32'(pending), 32'd0);
        check("final_count", 32'(fifo_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
